// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Segment patterns, BCD codes and FSM encoding shared by the
//             seven-segment encoder and the scan-capture receiver.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Active-high segment patterns {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_ILLEGAL = 4'hE;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef struct packed {
        logic [3:0] bcd;
        logic       illegal;
    } seg_dec_t;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_capture_if
//  Brief    : Multiplexed seven-segment bus plus captured-frame outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   dig_sel;
    logic [4*NDIG-1:0] bcd_out;
    logic              frame_valid;
    logic              pattern_err;
    logic              seq_err;

    modport master (
        output seg, dig_sel,
        input  bcd_out, frame_valid, pattern_err, seq_err
    );

    modport slave (
        input  seg, dig_sel,
        output bcd_out, frame_valid, pattern_err, seq_err
    );
endinterface
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pattern_decode
//  Brief    : Combinational seven-segment pattern to BCD; blank maps to F,
//             anything unrecognised maps to E and flags illegal.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_pattern_decode (
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       illegal_o
);
    import seg7_pkg::*;

    seg_dec_t w_dec;

    always_comb begin
        w_dec = '{bcd: BCD_ILLEGAL, illegal: 1'b1};
        case (seg_i)
            SEG_0:     w_dec = '{bcd: 4'd0, illegal: 1'b0};
            SEG_1:     w_dec = '{bcd: 4'd1, illegal: 1'b0};
            SEG_2:     w_dec = '{bcd: 4'd2, illegal: 1'b0};
            SEG_3:     w_dec = '{bcd: 4'd3, illegal: 1'b0};
            SEG_4:     w_dec = '{bcd: 4'd4, illegal: 1'b0};
            SEG_5:     w_dec = '{bcd: 4'd5, illegal: 1'b0};
            SEG_6:     w_dec = '{bcd: 4'd6, illegal: 1'b0};
            SEG_7:     w_dec = '{bcd: 4'd7, illegal: 1'b0};
            SEG_8:     w_dec = '{bcd: 4'd8, illegal: 1'b0};
            SEG_9:     w_dec = '{bcd: 4'd9, illegal: 1'b0};
            SEG_BLANK: w_dec = '{bcd: BCD_BLANK, illegal: 1'b0};
            default:   w_dec = '{bcd: BCD_ILLEGAL, illegal: 1'b1};
        endcase
    end

    assign bcd_o     = w_dec.bcd;
    assign illegal_o = w_dec.illegal;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_capture
//  Brief    : Samples a multiplexed seven-segment bus, debounces each digit,
//             decodes it to BCD and assembles complete ordered frames.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_capture_if.slave   bus
);
    import seg7_pkg::*;

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [6:0]        seg_q, seg_p_q;
    logic [NDIG-1:0]   dig_q, dig_p_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     exp_q, exp_d;
    logic [4*NDIG-1:0] stg_q, stg_d, bcd_q, bcd_d;
    logic              err_q, err_d;
    logic              fv_q, fv_d, perr_q, perr_d, serr_q, serr_d;

    logic              w_same, w_onehot, w_dig_chg, w_accept, w_ill;
    logic [IW-1:0]     w_idx;
    logic [3:0]        w_bcd;

    seg7_pattern_decode u_decode (
        .seg_i     (seg_q),
        .bcd_o     (w_bcd),
        .illegal_o (w_ill)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_q[i]) w_idx = IW'(i);
        end
    end

    // cnt_d is the run length (minus one) of the current sample; acceptance
    // is taken at most once per digit visit, a visit ending when dig_sel moves.
    always_comb begin
        w_same    = ({seg_q, dig_q} == {seg_p_q, dig_p_q});
        w_onehot  = $onehot(dig_q);
        w_dig_chg = (dig_q != dig_p_q);
        cnt_d     = '0;
        if (w_same && w_onehot) begin
            cnt_d = (cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + CW'(1);
        end
        w_accept = w_onehot && (cnt_d == CW'(STABLE_CYC - 1)) && !(acc_q && !w_dig_chg);
        acc_d    = w_dig_chg ? w_accept : (acc_q | w_accept);
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        stg_d   = stg_q;
        err_d   = err_q;
        bcd_d   = bcd_q;
        fv_d    = 1'b0;
        perr_d  = 1'b0;
        serr_d  = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (w_accept && w_idx == '0) begin
                    stg_d[3:0] = w_bcd;
                    err_d      = w_ill;
                    exp_d      = IW'(1);
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    if (w_idx == exp_q) begin
                        stg_d[4*w_idx +: 4] = w_bcd;
                        err_d               = err_q | w_ill;
                        exp_d               = exp_q + IW'(1);
                        if (exp_q == IW'(NDIG - 1)) state_d = ST_DONE;
                    end else if (w_idx == '0) begin
                        stg_d[3:0] = w_bcd;
                        err_d      = w_ill;
                        exp_d      = IW'(1);
                        serr_d     = 1'b1;
                    end else begin
                        serr_d  = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_DONE: begin
                bcd_d   = stg_q;
                fv_d    = 1'b1;
                perr_d  = err_q;
                state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= '0;
            dig_q   <= '0;
            seg_p_q <= '0;
            dig_p_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            state_q <= ST_HUNT;
            exp_q   <= '0;
            stg_q   <= '0;
            err_q   <= 1'b0;
            bcd_q   <= '0;
            fv_q    <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            seg_q   <= bus.seg;
            dig_q   <= bus.dig_sel;
            seg_p_q <= seg_q;
            dig_p_q <= dig_q;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            state_q <= state_d;
            exp_q   <= exp_d;
            stg_q   <= stg_d;
            err_q   <= err_d;
            bcd_q   <= bcd_d;
            fv_q    <= fv_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.frame_valid = fv_q;
    assign bus.pattern_err = perr_q;
    assign bus.seq_err     = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_capture
//  Brief    : Directed and random scans checked against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_capture;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_capture_if #(.NDIG(NDIG)) bif ();

    seg7_scan_capture #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int v);
        case (v)
            0: return 7'b1111110;  1: return 7'b0110000;
            2: return 7'b1101101;  3: return 7'b1111001;
            4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;
            8: return 7'b1111111;  9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // {illegal, bcd}
    function automatic logic [4:0] dec(input logic [6:0] s);
        for (int v = 0; v < 10; v++) if (enc(v) == s) return {1'b0, 4'(v)};
        if (s == 7'b0) return {1'b0, 4'hF};
        return {1'b1, 4'hE};
    endfunction

    // ---------------- reference model ----------------
    logic [6:0]      m_prev_seg;
    logic [NDIG-1:0] m_prev_dig;
    int              m_run;
    bit              m_visit_acc, m_collect, m_err;
    int              m_exp;
    logic [3:0]      m_stg [NDIG];
    bit              seq_d1, fv_d1, fv_d2, pe_d1, pe_d2;
    logic [15:0]     fr_d1, fr_d2;
    bit              e_seq, e_fv, e_pe;
    logic [15:0]     e_bcd;

    task automatic model_reset();
        m_prev_seg = '0; m_prev_dig = '0; m_run = 0; m_visit_acc = 0;
        m_collect = 0; m_err = 0; m_exp = 0;
        seq_d1 = 0; fv_d1 = 0; fv_d2 = 0; pe_d1 = 0; pe_d2 = 0;
        fr_d1 = '0; fr_d2 = '0;
        e_seq = 0; e_fv = 0; e_pe = 0; e_bcd = '0;
    endtask

    task automatic model_accept(input int d, input logic [6:0] s);
        logic [4:0] r;
        r = dec(s);
        if (!m_collect) begin
            if (d == 0) begin
                m_stg[0] = r[3:0]; m_err = r[4]; m_exp = 1; m_collect = 1;
            end
        end else if (d == m_exp) begin
            m_stg[d] = r[3:0];
            m_err    = m_err | r[4];
            if (m_exp == NDIG - 1) begin
                m_collect = 0; fv_d2 = 1; pe_d2 = m_err;
                for (int i = 0; i < NDIG; i++) fr_d2[4*i +: 4] = m_stg[i];
            end else begin
                m_exp++;
            end
        end else if (d == 0) begin
            seq_d1 = 1; m_stg[0] = r[3:0]; m_err = r[4]; m_exp = 1;
        end else begin
            seq_d1 = 1; m_collect = 0;
        end
    endtask

    // One sampling edge: seq_err shows one cycle after acceptance, frames two.
    task automatic model_step(input logic [6:0] s, input logic [NDIG-1:0] dg);
        e_seq = seq_d1; seq_d1 = 0;
        e_fv  = fv_d1;  e_pe = pe_d1;
        if (fv_d1) e_bcd = fr_d1;
        fv_d1 = fv_d2; fr_d1 = fr_d2; pe_d1 = pe_d2; fv_d2 = 0;
        if (s == m_prev_seg && dg == m_prev_dig) m_run++;
        else m_run = 1;
        if (dg != m_prev_dig) m_visit_acc = 0;
        m_prev_seg = s; m_prev_dig = dg;
        if ($countones(dg) == 1 && m_run >= STABLE && !m_visit_acc) begin
            m_visit_acc = 1;
            for (int i = 0; i < NDIG; i++) if (dg[i]) model_accept(i, s);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [6:0] s, input logic [NDIG-1:0] dg);
        bif.seg = s; bif.dig_sel = dg;
        @(posedge clk);
        model_step(s, dg);
        #1;
        check("frame_valid", 32'(bif.frame_valid), 32'(e_fv));
        check("seq_err", 32'(bif.seq_err), 32'(e_seq));
        check("bcd_out", 32'(bif.bcd_out), 32'(e_bcd));
        if (e_fv) check("pattern_err", 32'(bif.pattern_err), 32'(e_pe));
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        logic [NDIG-1:0] dg;
        dg = NDIG'(1) << d;
        repeat (n) cyc(s, dg);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(7'b0, '0);
    endtask

    initial begin
        int r, dd, n;
        logic [6:0] s;
        logic [NDIG-1:0] dg;

        bif.seg = '0; bif.dig_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_bcd", 32'(bif.bcd_out), 32'h0);
        check("reset_fv", 32'(bif.frame_valid), 32'h0);
        check("reset_seq", 32'(bif.seq_err), 32'h0);
        check("reset_perr", 32'(bif.pattern_err), 32'h0);
        rst_n = 1'b1;

        // basic scan
        show(0, enc(1), 5); show(1, enc(2), 5); show(2, enc(3), 5); show(3, enc(4), 5);
        idle(3);
        check("scan_bcd", 32'(bif.bcd_out), 32'h4321);

        // round trip of every digit value through every slot
        for (int v = 0; v < 10; v++) begin
            for (int d = 0; d < NDIG; d++) show(d, enc((v + d) % 10), 4);
            idle(3);
        end
        check("roundtrip_last", 32'(bif.bcd_out), 32'h2109);

        // illegal pattern on digit 1
        show(0, enc(8), 4); show(1, 7'b1111100, 4); show(2, enc(6), 4); show(3, enc(7), 4);
        idle(3);
        check("illegal_bcd", 32'(bif.bcd_out), 32'h76E8);

        // short glitch on digit 1, blank digit 2
        show(0, enc(0), 4); show(1, enc(7), 2); show(1, enc(5), 4);
        show(2, 7'b0, 4); show(3, enc(9), 4);
        idle(3);
        check("glitch_bcd", 32'(bif.bcd_out), 32'h9F50);

        // out-of-order digit aborts, then a clean frame
        show(0, enc(1), 4); show(1, enc(1), 4); show(3, enc(1), 4);
        idle(4);
        check("abort_hold", 32'(bif.bcd_out), 32'h9F50);
        for (int d = 0; d < NDIG; d++) show(d, enc(d + 5), 4);
        idle(3);
        check("after_abort", 32'(bif.bcd_out), 32'h8765);

        // asynchronous reset in the middle of a frame
        show(0, enc(5), 5); show(1, enc(6), 5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_bcd", 32'(bif.bcd_out), 32'h0);
        check("async_rst_fv", 32'(bif.frame_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        show(2, enc(3), 5); show(3, enc(4), 5);
        idle(4);
        check("post_rst_bcd", 32'(bif.bcd_out), 32'h0);

        // random scans with occasional reorder, glitches, bad selects and patterns
        for (int f = 0; f < 40; f++) begin
            for (int d = 0; d < NDIG; d++) begin
                dd = d;
                if ($urandom_range(0, 14) == 0) dd = int'($urandom_range(0, NDIG - 1));
                r = int'($urandom_range(0, 11));
                if (r < 10)       s = enc(r);
                else if (r == 10) s = 7'b0;
                else              s = 7'($urandom);
                dg = NDIG'(1) << dd;
                if ($urandom_range(0, 19) == 0) dg = NDIG'($urandom);
                n = int'($urandom_range(1, 6));
                repeat (n) cyc(s, dg);
            end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
